chirp_window_shaper: RTL and testbench

Applies a linear amplitude taper (ramp-up, unity hold, ramp-down) to the I/Q sample stream from the chirp DDS in the clk_96 domain, so that each transmitted chirp pulse has bounded spectral splatter. It sits directly downstream of the DDS chirp generator. It consumes the generator's `data_I`/`data_Q`/`valid` outputs plus the same `start` gate, and feeds the DAC/packer path. The pulse length in samples is latched per pulse; the ramp length is fixed at build time.

---
 rtl/chirp_window_shaper_if.sv | 22 ++
 rtl/chirp_window_shaper.sv | 194 +++++++++++++++++++
 tb/tb_chirp_window_shaper.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/chirp_window_shaper_if.sv
// chirp_window_shaper_if: I/Q sample stream into and out of the chirp window shaper.
// Handshake: valid-only stream with no back-pressure. A sample is transferred
// on every rising clk_96 edge where *_valid is high; data is don't-care otherwise.
// The master drives din_* and observes dout_*; the shaper is the slave.
interface chirp_window_shaper_if;
  logic signed [15:0] din_I;
  logic signed [15:0] din_Q;
  logic               din_valid;
  logic signed [15:0] dout_I;
  logic signed [15:0] dout_Q;
  logic               dout_valid;

  modport master (
    output din_I, din_Q, din_valid,
    input  dout_I, dout_Q, dout_valid
  );

  modport slave (
    input  din_I, din_Q, din_valid,
    output dout_I, dout_Q, dout_valid
  );
endinterface

// File: rtl/chirp_window_shaper.sv
// chirp_window_shaper: linear ramp-up / unity hold / ramp-down amplitude taper
// applied to each DDS chirp pulse. Ramp length N = 2^RAMP_LOG2 samples, pulse
// length latched on the start rise and clamped to at least 2N.
// Build option: define CHIRP_WIN_ROUND_EN for round-half-up on the final
// >>>15; without it the shift truncates toward minus infinity.
// state_o exposes the FSM state (IDLE=0, UP=1, HOLD=2, DOWN=3, DONE=4).
module chirp_window_shaper #(
  parameter int RAMP_LOG2 = 6
) (
  input  logic                 clk_96,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          pulse_len,
  chirp_window_shaper_if.slave s,
  output logic                 busy,
  output logic                 pulse_done,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UP   = 3'd1,
    S_HOLD = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam int          N       = 1 << RAMP_LOG2;
  localparam int          STEP_SH = 15 - RAMP_LOG2;
  localparam logic [31:0] N_W     = 32'(N);
  localparam logic [31:0] TWO_N   = 32'(2 * N);

`ifdef CHIRP_WIN_ROUND_EN
  localparam logic signed [32:0] RND = 33'sd16384;
`else
  localparam logic signed [32:0] RND = 33'sd0;
`endif

  // start synchroniser and edge register
  logic start_meta_q, start_sync_q, start_prev_q;
  logic start_rise, start_fall;

  // control
  state_t      state_q;
  logic [31:0] k_q;
  logic [31:0] l_q;
  logic        busy_q;
  logic        in_run, acc, abort, last_k;

  // datapath
  logic [15:0]        gain;
  logic [31:0]        down_idx;
  logic signed [32:0] prod_i, prod_q;
  logic signed [32:0] p_i_q, p_q_q;
  logic signed [32:0] sum_i, sum_q;
  logic               vld1_q, last1_q;
  logic signed [15:0] dout_i_q, dout_q_q;
  logic               dout_valid_q, done_q;
  logic               unused_bits;

  // Sync flops reset high so a start held high across reset is not seen as a
  // rise; it must first be sampled low.
  always_ff @(posedge clk_96 or posedge rst) begin
    if (rst) begin
      start_meta_q <= 1'b1;
      start_sync_q <= 1'b1;
      start_prev_q <= 1'b1;
    end else begin
      start_meta_q <= start;
      start_sync_q <= start_meta_q;
      start_prev_q <= start_sync_q;
    end
  end

  assign start_rise = start_sync_q & ~start_prev_q;
  assign start_fall = ~start_sync_q & start_prev_q;

  assign in_run = (state_q == S_UP) || (state_q == S_HOLD) || (state_q == S_DOWN);
  assign acc    = s.din_valid & in_run;
  assign abort  = start_fall & in_run;
  assign last_k = (k_q == l_q - 32'd1);

  // Pulse FSM: latches length on rise, advances on accepted samples, aborts on fall.
  always_ff @(posedge clk_96 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= 32'd0;
      l_q     <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_rise) begin
            state_q <= S_UP;
            busy_q  <= 1'b1;
            k_q     <= 32'd0;
            l_q     <= (pulse_len < TWO_N) ? TWO_N : pulse_len;
          end
        end
        S_UP, S_HOLD, S_DOWN: begin
          if (abort) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if (acc) begin
            k_q <= k_q + 32'd1;
            if (state_q == S_UP) begin
              if (k_q == N_W - 32'd1) begin
                state_q <= (l_q == TWO_N) ? S_DOWN : S_HOLD;
              end
            end else if (state_q == S_HOLD) begin
              if (k_q == l_q - N_W - 32'd1) begin
                state_q <= S_DOWN;
              end
            end else if (last_k) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (start_fall) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Gain for the sample currently on din: k*step, unity, or (L-1-k)*step.
  always_comb begin
    gain     = 16'd0;
    down_idx = l_q - 32'd1 - k_q;
    case (state_q)
      S_UP:    gain = 16'(k_q[RAMP_LOG2-1:0]) << STEP_SH;
      S_HOLD:  gain = 16'h8000;
      S_DOWN:  gain = 16'(down_idx[RAMP_LOG2-1:0]) << STEP_SH;
      default: gain = 16'd0;
    endcase
  end

  // Signed 16 x unsigned 16 -> 33-bit signed; both operands widened to 33 bits.
  assign prod_i = $signed({{17{s.din_I[15]}}, s.din_I}) * $signed({17'd0, gain});
  assign prod_q = $signed({{17{s.din_Q[15]}}, s.din_Q}) * $signed({17'd0, gain});

  // Final scale: optional half-LSB bias, then >>>15 taken as bits [30:15].
  assign sum_i = p_i_q + RND;
  assign sum_q = p_q_q + RND;
  assign unused_bits = ^{down_idx[31:RAMP_LOG2], sum_i[32:31], sum_i[14:0],
                         sum_q[32:31], sum_q[14:0]};

  // Two-stage pipeline: product register, then scaled output; abort kills both valids.
  always_ff @(posedge clk_96 or posedge rst) begin
    if (rst) begin
      p_i_q        <= '0;
      p_q_q        <= '0;
      vld1_q       <= 1'b0;
      last1_q      <= 1'b0;
      dout_i_q     <= '0;
      dout_q_q     <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (acc) begin
        p_i_q <= prod_i;
        p_q_q <= prod_q;
      end
      vld1_q  <= acc & ~abort;
      last1_q <= acc & ~abort & (state_q == S_DOWN) & last_k;
      if (abort) begin
        dout_valid_q <= 1'b0;
        done_q       <= 1'b0;
      end else begin
        dout_valid_q <= vld1_q;
        done_q       <= last1_q;
      end
      if (vld1_q) begin
        dout_i_q <= sum_i[30:15];
        dout_q_q <= sum_q[30:15];
      end
    end
  end

  assign s.dout_I     = dout_i_q;
  assign s.dout_Q     = dout_q_q;
  assign s.dout_valid = dout_valid_q;
  assign pulse_done   = done_q;
  assign busy         = busy_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_chirp_window_shaper.sv
// tb_chirp_window_shaper: directed scoreboard bench for chirp_window_shaper
// with RAMP_LOG2 = 2 (N = 4, gain step 8192).
module tb_chirp_window_shaper;

  localparam int ST_IDLE = 0;
  localparam int ST_UP   = 1;
  localparam int ST_HOLD = 2;
  localparam int ST_DONE = 4;

  logic        clk_96 = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pulse_len;
  logic        busy;
  logic        pulse_done;
  logic [2:0]  state_o;
  int          cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {pulse_done, dout_I, dout_Q} and expected output cycle
  logic [32:0] exp_q[$];
  int          exp_t_q[$];
  logic [32:0] mon_e;
  int          mon_t;

  chirp_window_shaper_if bus();

  chirp_window_shaper #(.RAMP_LOG2(2)) dut (
    .clk_96     (clk_96),
    .rst        (rst),
    .start      (start),
    .pulse_len  (pulse_len),
    .s          (bus.slave),
    .busy       (busy),
    .pulse_done (pulse_done),
    .state_o    (state_o)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_96 = ~clk_96;
  always @(posedge clk_96) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk_96);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    step(n);
  endtask

  // Present one sample for one cycle; if push, queue its expected output,
  // due two cycles after the cycle it was presented in.
  task automatic send(input int di, input int dq, input bit push,
                      input int ei, input int eq, input bit ed);
    int t0;
    t0 = cyc;
    bus.din_I     = 16'(di);
    bus.din_Q     = 16'(dq);
    bus.din_valid = 1'b1;
    step(1);
    if (push) begin
      exp_q.push_back({ed, 16'(ei), 16'(eq)});
      exp_t_q.push_back(t0 + 2);
    end
  endtask

  task automatic start_pulse(input int len);
    bus.din_valid = 1'b0;
    pulse_len = 32'(len);
    start = 1'b1;
    step(2);
    chk("rise_not_early", state_o, ST_IDLE);
    step(1);
    chk("rise_state", state_o, ST_UP);
    chk("rise_busy", busy, 1);
  endtask

  task automatic end_pulse();
    bus.din_valid = 1'b0;
    start = 1'b0;
    step(3);
    chk("fall_state", state_o, ST_IDLE);
    chk("fall_busy", busy, 0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk_96) begin
    if (!rst) begin
      if (bus.dout_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out: got I=%0d Q=%0d expected no output (t=%0t)",
                   bus.dout_I, bus.dout_Q, $time);
        end else begin
          mon_e = exp_q.pop_front();
          mon_t = exp_t_q.pop_front();
          chk("dout_I", bus.dout_I, $signed(mon_e[31:16]));
          chk("dout_Q", bus.dout_Q, $signed(mon_e[15:0]));
          chk("pulse_done", pulse_done, mon_e[32]);
          chk("out_cycle", cyc, mon_t);
        end
      end else begin
        chk("stray_done", pulse_done, 0);
      end
    end
  end

  // ---------------- stimulus tables ----------------
  int taper_i [10] = '{0, 4096, 8192, 12288, 16384, 16384, 12288, 8192, 4096, 0};
  int short_i [8]  = '{0, 4096, 8192, 12288, 12288, 8192, 4096, 0};
  int short_q [8]  = '{0, -5000, -10000, -15000, -15000, -10000, -5000, 0};
  int rnd_di  [8]  = '{100, 5, 3, 7, -1, 2, 32767, 32767};
  int rnd_dq  [8]  = '{-100, -5, -3, -7, 1, -2, -32768, -32768};
`ifdef CHIRP_WIN_ROUND_EN
  int rnd_ei  [8]  = '{0, 1, 2, 5, -1, 1, 8192, 0};
  int rnd_eq  [8]  = '{0, -1, -1, -5, 1, -1, -8192, 0};
`else
  int rnd_ei  [8]  = '{0, 1, 1, 5, -1, 1, 8191, 0};
  int rnd_eq  [8]  = '{0, -2, -2, -6, 0, -1, -8192, 0};
`endif
  int up_i    [4]  = '{0, 250, 500, 750};

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1;
    start = 1'b0;
    pulse_len = 32'd0;
    bus.din_I = '0;
    bus.din_Q = '0;
    bus.din_valid = 1'b0;
    step(3);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout_I", bus.dout_I, 0);
    chk("rst_dout_Q", bus.dout_Q, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulse_done", pulse_done, 0);
    chk("rst_state", state_o, ST_IDLE);
    rst = 1'b0;
    step(3);

    // Basic taper: L = 10, din = 16384 on both channels.
    start_pulse(10);
    for (int k = 0; k < 10; k++) send(16384, 16384, 1, taper_i[k], taper_i[k], k == 9);
    chk("taper_done_state", state_o, ST_DONE);
    chk("taper_done_busy", busy, 0);
    idle(4);
    end_pulse();

    // Rounding behaviour on a 2N pulse (UP goes straight to DOWN).
    start_pulse(8);
    for (int k = 0; k < 8; k++) send(rnd_di[k], rnd_dq[k], 1, rnd_ei[k], rnd_eq[k], k == 7);
    idle(4);
    end_pulse();

    // Abort: drop start after sample 19. Sample 20 still emerges; 21 and 22 are killed.
    start_pulse(100);
    for (int k = 0; k < 20; k++)
      send(1000, -1000, 1, (k < 4) ? up_i[k] : 1000, (k < 4) ? -up_i[k] : -1000, 0);
    start = 1'b0;
    send(1000, -1000, 1, 1000, -1000, 0);
    send(1000, -1000, 0, 0, 0, 0);
    chk("abort_not_early", state_o, ST_HOLD);
    send(1000, -1000, 0, 0, 0, 0);
    chk("abort_dout_valid", bus.dout_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_state", state_o, ST_IDLE);
    idle(4);

    // Restart after abort begins at gain 0, then unity-gain extremes with 1-on/2-off gaps.
    start_pulse(100);
    for (int k = 0; k < 4; k++) send(1000, -1000, 1, up_i[k], -up_i[k], 0);
    for (int j = 0; j < 4; j++) begin
      if (j % 2 == 0) send(-32768, 32767, 1, -32768, 32767, 0);
      else            send(32767, -32768, 1, 32767, -32768, 0);
      idle(2);
    end
    idle(2);
    end_pulse();

    // Reset mid-pulse with start held high across reset.
    start_pulse(100);
    for (int k = 0; k < 6; k++)
      send(1000, -1000, k < 4, (k < 4) ? up_i[k] : 0, (k < 4) ? -up_i[k] : 0, 0);
    chk("prerst_dout_valid", bus.dout_valid, 1);
    chk("prerst_state", state_o, ST_HOLD);
    rst = 1'b1;
    bus.din_valid = 1'b0;
    #1;
    chk("midrst_dout_valid", bus.dout_valid, 0);
    chk("midrst_dout_I", bus.dout_I, 0);
    chk("midrst_dout_Q", bus.dout_Q, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pulse_done", pulse_done, 0);
    chk("midrst_state", state_o, ST_IDLE);
    step(3);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) send(1000, -1000, 0, 0, 0, 0);
    idle(3);
    chk("held_start_state", state_o, ST_IDLE);
    chk("held_start_busy", busy, 0);
    start = 1'b0;
    step(3);

    // Short pulse: pulse_len 3 clamps to 2N = 8 samples.
    start_pulse(3);
    for (int k = 0; k < 8; k++) send(16384, -20000, 1, short_i[k], short_q[k], k == 7);
    chk("short_done_state", state_o, ST_DONE);
    idle(4);
    end_pulse();

    idle(4);
    chk("drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
